ifetch_resp: RTL
================

# ifetch_resp

Instruction-fetch responder for the RV32I single-cycle/pipelined core: accepts word fetch requests from the program-counter side and returns instructions from an on-chip instruction memory. Responses return over a valid/ready handshake, buffered in a small in-order FIFO. A flush input discards all buffered responses on a control-flow redirect. A side load port writes program words into the memory.

## Interface

Parameters:
- DEPTH, 1024: instruction memory size in 32-bit words (power of two).
- FIFO_DEPTH, 2: response buffer entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address of the instruction.
- flush  in  1  drop all buffered responses; block acceptance this cycle.
- resp_valid  out  1  FIFO head holds a response.
- resp_ready  in  1  consumer takes the head this cycle.
- resp_instr  out  32  instruction word at the head.
- resp_addr  out  32  req_addr that produced the head entry.
- resp_fault  out  1  head entry is a misaligned fetch (see Configuration).
- load_en  in  1  write load_data into memory.
- load_addr  in  32  byte address for the load write.
- load_data  in  32  word to write.

## Operation

- Accept = req_valid && req_ready.
- req_ready = !flush && (count < FIFO_DEPTH). It does not depend on resp_ready; a full FIFO refuses a push even when popping that cycle.
- On accept, the FIFO tail is written with {mem[req_addr[ADDR_W+1:2]], req_addr, fault}, where ADDR_W = log2(DEPTH). Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Pop = resp_valid && resp_ready. A pop advances the head.
- Push and pop in the same cycle leave count unchanged.
- Responses are strictly in request order.
- Flush clears count, head and tail on that edge. Any pop that cycle is void. No push occurs, because req_ready is low.
- Load write: mem[load_addr[ADDR_W+1:2]] <= load_data. If a load and an accept hit the same word in the same cycle, the response carries the old contents (read-before-write).
- Memory contents are not reset.
- Reset: count=0, resp_valid=0, resp_instr=0, resp_addr=0, resp_fault=0, req_ready=1 the cycle after rst is deasserted.
- Reset asserted mid-operation drops all buffered entries. No response is produced for a request accepted in the same cycle as rst.

## Timing

- Latency: a request accepted at edge N has resp_valid=1 from cycle N+1, provided the FIFO was otherwise empty.
- Throughput: 1 request/cycle sustained while resp_ready is held high, given FIFO_DEPTH ≥ 2.
- resp_* are driven from FIFO registers only, with no combinational path from req_*.
- req_ready is combinational only from flush and registered count.
- resp_* are stable while resp_valid && !resp_ready, except that flush or rst may withdraw them.

## Configuration

- IFETCH_MISALIGN_CHECK_EN defined:
  - req_addr[1:0] != 0 sets fault=1 in the entry.
  - resp_instr is replaced by NOP_INSTR (32'h0000_0013); the memory read is discarded.
- Undefined:
  - resp_fault is tied 0.
  - req_addr[1:0] are ignored; the word at the truncated address is returned.

## Structure

- Package ifetch_pkg:
  - NOP_INSTR constant.
  - ifetch_entry_t struct {instr[31:0], addr[31:0], fault}.
- Sub-module ifetch_fifo: parameterised synchronous FIFO of ifetch_entry_t with push, pop, clear, count and full/empty. Top level holds the memory array, the ready logic and the fault check.

## Test plan

- Back-to-back streaming: load mem[0..3] = 0x11,0x22,0x33,0x44; request addrs 0,4,8,12 on consecutive cycles with resp_ready=1 → resp_instr 0x11..0x44 on cycles 1..4, resp_addr matching, no bubbles.
- Backpressure and full: resp_ready=0; issue 3 requests → 2 accepted, req_ready=0 on cycle 2. Raise resp_ready → responses in order; third request accepted only after count < 2.
- Flush with 2 buffered and req_valid high: resp_valid=0 the next cycle, no request accepted in the flush cycle. Request at 0x100 the cycle after → resp_addr=0x100 at latency 1.
- Load/read collision: mem[5]=0xAAAA; same cycle load_addr=20, load_data=0xBBBB and request addr 20 → response 0xAAAA. A re-request returns 0xBBBB.
- Misaligned: request addr 0x6.
  - With IFETCH_MISALIGN_CHECK_EN: resp_fault=1, resp_instr=0x00000013.
  - Without it: resp_fault=0, resp_instr=mem[1].
- Reset mid-stream: assert rst with 2 entries buffered → resp_valid=0 and resp_instr/resp_addr=0 next cycle; memory contents preserved on subsequent fetch.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package ifetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        fault;
   } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// In-order response buffer of ifetch_entry_t with push/pop/clear and occupancy.
// Pushes while full and pops while empty are ignored; clear wins over both.
import ifetch_pkg::*;

module ifetch_fifo #(
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic                    i_clear,
   input  ifetch_entry_t           i_wdata,
   output ifetch_entry_t           o_rdata,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic                    o_full,
   output logic                    o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   ifetch_entry_t      r_mem [DEPTH];
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [CNT_W-1:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: pointers and count decide what is visible.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_tail] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[r_head];
   assign o_count = r_count;

endmodule

// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: word memory with a side load port feeding an
// in-order response FIFO. Optional misalignment faulting: IFETCH_MISALIGN_CHECK_EN.
import ifetch_pkg::*;

module ifetch_resp #(
   parameter int DEPTH      = 1024,
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        flush,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_instr,
   output logic [31:0] resp_addr,
   output logic        resp_fault,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]       r_mem [DEPTH];
   logic [ADDR_W-1:0] w_rd_idx;
   logic [ADDR_W-1:0] w_wr_idx;
   logic [31:0]       w_rd_word;
   logic              w_accept;
   logic              w_pop;
   logic              w_empty;
   logic              w_full;
   logic [CNT_W-1:0]  w_count;
   ifetch_entry_t     w_push_entry;
   ifetch_entry_t     w_head;
   logic              w_unused_bits;

   assign w_rd_idx = req_addr[ADDR_W+1:2];
   assign w_wr_idx = load_addr[ADDR_W+1:2];

   // The read samples the word before this edge's load, giving read-before-write.
   assign w_rd_word = r_mem[w_rd_idx];

   always_ff @(posedge clk) begin
      if (load_en) begin
         r_mem[w_wr_idx] <= load_data;
      end
   end

   assign req_ready = !flush && (w_count < CNT_W'(FIFO_DEPTH));
   assign w_accept  = req_valid && req_ready;
   assign w_pop     = resp_valid && resp_ready;

   always_comb begin
      w_push_entry.addr  = req_addr;
`ifdef IFETCH_MISALIGN_CHECK_EN
      w_push_entry.fault = (req_addr[1:0] != 2'b00);
      w_push_entry.instr = w_push_entry.fault ? NOP_INSTR : w_rd_word;
`else
      w_push_entry.fault = 1'b0;
      w_push_entry.instr = w_rd_word;
`endif
   end

   ifetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_accept),
      .i_pop   (w_pop),
      .i_clear (flush),
      .i_wdata (w_push_entry),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Outputs read as zero whenever the buffer is empty, including after reset.
   assign resp_valid = !w_empty;
   assign resp_instr = resp_valid ? w_head.instr : 32'h0;
   assign resp_addr  = resp_valid ? w_head.addr  : 32'h0;
   assign resp_fault = resp_valid && w_head.fault;

   assign w_unused_bits = &{1'b0, req_addr[31:ADDR_W+2], load_addr[31:ADDR_W+2],
                            load_addr[1:0], w_full};

endmodule
